// File: rtl/smachine_io_pkg.sv
// Shared definitions for the S-Machine memory-mapped switch/LED I/O port.
// Holds register offsets, event bit positions, bus data type and the
// window-decode helper used by smachine_io_port.
package smachine_io_pkg;

  localparam int unsigned IO_DW    = 8;
  localparam int unsigned IO_AW    = 8;
  localparam int unsigned IO_NEV   = 4;
  localparam int unsigned IO_NLED  = 2;
  localparam int unsigned IO_CNT_W = 8;

  typedef logic [IO_DW-1:0] io_data_t;

  // Register offsets inside the 4-byte window
  localparam logic [1:0] IO_OFF_SW_STATE = 2'd0;
  localparam logic [1:0] IO_OFF_SW_EVENT = 2'd1;
  localparam logic [1:0] IO_OFF_LED      = 2'd2;
  localparam logic [1:0] IO_OFF_IRQ_MASK = 2'd3;

  // Bit positions inside SW_EVENT
  localparam int unsigned EV_SW0_RISE = 0;
  localparam int unsigned EV_SW1_RISE = 1;
  localparam int unsigned EV_SW0_FALL = 2;
  localparam int unsigned EV_SW1_FALL = 3;

  // Decoded bus access presented to the register file
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] off;
    io_data_t   data;
  } io_access_t;

  // True when addr falls inside the 4-byte window starting at base
  function automatic logic io_hit(input logic [IO_AW-1:0] addr,
                                  input logic [IO_AW-1:0] base);
    return addr[IO_AW-1:2] == base[IO_AW-1:2];
  endfunction

endpackage

// File: rtl/smachine_switch_debounce.sv
// Two-flop synchroniser plus counter debounce for one asynchronous switch.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sw_async         raw board switch
//   stable           debounced level (registered)
//   rise, fall       one-cycle pulses, asserted in the cycle stable changes
// A change on sw_async reaches stable after 2 + DEBOUNCE_CYCLES clocks; a
// synchronised glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
module smachine_switch_debounce
  import smachine_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [IO_CNT_W-1:0] CNT_LAST = IO_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IO_CNT_W-1:0] CNT_ONE  = IO_CNT_W'(1);

  logic                meta;
  logic                sync;
  logic [IO_CNT_W-1:0] cnt;

  // Synchroniser, stability counter and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta <= sw_async;
      sync <= meta;
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
        rise   <= sync;
        fall   <= ~sync;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/smachine_io_port.sv
// Memory-mapped switch/LED I/O port on the CPU side of the S-Machine board.
// Register window (base IO_BASE, 4 bytes):
//   +0 SW_STATE (RO)  {6'b0, stable1, stable0}
//   +1 SW_EVENT (W1C) [0] sw0 rise [1] sw1 rise [2] sw0 fall [3] sw1 fall
//   +2 LED      (RW)  [1:0]
//   +3 IRQ_MASK (RW)  [3:0] when IO_PORT_IRQ_EN is defined, else reads 0
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   enable, addr, wdata     CPU bus enable, address, write data
//   wr_en, rd_en            single-cycle write / read strobes
//   rdata, rd_valid         registered read data, one-cycle valid pulse
//   switch0, switch1        asynchronous board switches
//   led0, led1              LED drives straight from the LED register
//   irq                     (IO_PORT_IRQ_EN only) |(SW_EVENT & IRQ_MASK)
// Configuration macro: IO_PORT_IRQ_EN.
module smachine_io_port
  import smachine_io_pkg::*;
#(
  parameter logic [IO_AW-1:0] IO_BASE         = 8'hF0,
  parameter int unsigned      DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [IO_AW-1:0] addr,
  input  io_data_t         wdata,
  input  logic             wr_en,
  input  logic             rd_en,
  output io_data_t         rdata,
  output logic             rd_valid,
  input  logic             switch0,
  input  logic             switch1,
  output logic             led0,
  output logic             led1
`ifdef IO_PORT_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic              stable0, stable1;
  logic              rise0, rise1, fall0, fall1;
  io_access_t        acc;
  logic              hit;
  logic [IO_NLED-1:0] led_q;
  logic [IO_NEV-1:0] ev_q;
  logic [IO_NEV-1:0] ev_set;
  logic [IO_NEV-1:0] ev_clr;
  logic [IO_NEV-1:0] ev_next;
  io_data_t          rd_mux;
  logic              unused_wdata;

  // Upper write-data bits have no storage behind them
  assign unused_wdata = ^wdata[IO_DW-1:IO_NEV];

  // Debouncers run continuously, independent of the bus enable
  smachine_switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_async(switch0),
    .stable  (stable0),
    .rise    (rise0),
    .fall    (fall0)
  );

  smachine_switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_async(switch1),
    .stable  (stable1),
    .rise    (rise1),
    .fall    (fall1)
  );

  // Bus decode
  always_comb begin
    hit      = enable && io_hit(addr, IO_BASE);
    acc.wr   = hit && wr_en;
    acc.rd   = hit && rd_en;
    acc.off  = addr[1:0];
    acc.data = wdata;
  end

  // Event flag update: W1C clear first, then set so a coincident set wins
  always_comb begin
    ev_set              = '0;
    ev_set[EV_SW0_RISE] = rise0;
    ev_set[EV_SW1_RISE] = rise1;
    ev_set[EV_SW0_FALL] = fall0;
    ev_set[EV_SW1_FALL] = fall1;
    ev_clr              = '0;
    if (acc.wr && (acc.off == IO_OFF_SW_EVENT)) begin
      ev_clr = acc.data[IO_NEV-1:0];
    end
    ev_next = (ev_q & ~ev_clr) | ev_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= '0;
    end else begin
      ev_q <= ev_next;
    end
  end

  // LED register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else if (acc.wr && (acc.off == IO_OFF_LED)) begin
      led_q <= acc.data[IO_NLED-1:0];
    end
  end

  assign led0 = led_q[0];
  assign led1 = led_q[1];

`ifdef IO_PORT_IRQ_EN
  logic [IO_NEV-1:0] mask_q;

  // Interrupt mask register and registered interrupt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (acc.wr && (acc.off == IO_OFF_IRQ_MASK)) begin
        mask_q <= acc.data[IO_NEV-1:0];
      end
      irq <= |(ev_q & mask_q);
    end
  end
`endif

  // Read mux over current (pre-write) register contents
  always_comb begin
    rd_mux = '0;
    case (acc.off)
      IO_OFF_SW_STATE: rd_mux = {6'b0, stable1, stable0};
      IO_OFF_SW_EVENT: rd_mux = IO_DW'(ev_q);
      IO_OFF_LED:      rd_mux = IO_DW'(led_q);
`ifdef IO_PORT_IRQ_EN
      IO_OFF_IRQ_MASK: rd_mux = IO_DW'(mask_q);
`endif
      default:         rd_mux = '0;
    endcase
  end

  // Read response: rdata holds its value when no read hits the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= acc.rd;
      if (acc.rd) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_smachine_io_port.sv
// Self-checking bench for smachine_io_port (DEBOUNCE_CYCLES = 4, IO_BASE = F0).
// Expected read data is queued when a read is issued and checked when
// rd_valid returns.
module tb_smachine_io_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       switch0;
  logic       switch1;
  logic       led0;
  logic       led1;
`ifdef IO_PORT_IRQ_EN
  logic       irq;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  smachine_io_port #(
    .IO_BASE        (8'hF0),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .addr    (addr),
    .wdata   (wdata),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .rd_valid(rd_valid),
    .switch0 (switch0),
    .switch1 (switch1),
    .led0    (led0),
    .led1    (led1)
`ifdef IO_PORT_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  // Advance to the next falling edge and retire any returned read
  task automatic tick();
    logic [7:0] e;
    string      nm;
    @(negedge clk);
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 rdata=%h with no read outstanding", rdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL %s: rdata=%h expected=%h", nm, rdata, e);
        end
      end
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] e, input string nm);
    addr  = a;
    rd_en = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: rd_valid=%b expected=1", nm, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_drop: rd_valid=%b expected=0", nm, rd_valid);
    end
  endtask

  task automatic check_leds(input logic e0, input logic e1, input string nm);
    checks++;
    if (led0 !== e0 || led1 !== e1) begin
      errors++;
      $display("FAIL %s: led1,led0=%b%b expected=%b%b", nm, led1, led0, e1, e0);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    enable  = 1'b1;
    addr    = 8'h00;
    wdata   = 8'h00;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    switch0 = 1'b1;
    switch1 = 1'b0;
    #23;
    check_leds(1'b0, 1'b0, "reset_leds");
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: rdata=%h expected=00", rdata);
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_valid: rd_valid=%b expected=0", rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
    do_read(8'hF0, 8'h01, "reset_sw_state");
    do_read(8'hF1, 8'h01, "reset_sw0_rise");
    do_write(8'hF1, 8'h0F);
    do_read(8'hF1, 8'h00, "reset_event_cleared");
  endtask

  task automatic test_led();
    do_write(8'hF2, 8'hFF);
    check_leds(1'b1, 1'b1, "led_ff");
    do_read(8'hF2, 8'h03, "led_read_ff");
    do_write(8'hF2, 8'h01);
    check_leds(1'b1, 1'b0, "led_01");
    do_read(8'hF2, 8'h01, "led_read_01");
    do_write(8'hF2, 8'hFF);
  endtask

  task automatic test_glitch();
    switch1 = 1'b1;
    repeat (3) tick();
    switch1 = 1'b0;
    repeat (10) tick();
    do_read(8'hF0, 8'h01, "glitch_sw_state");
    do_read(8'hF1, 8'h00, "glitch_sw_event");
  endtask

  // Streams reads of SW_STATE every cycle to pin the 6-cycle latency
  task automatic test_debounce();
    switch1 = 1'b1;
    addr    = 8'hF0;
    rd_en   = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      exp_q.push_back((j <= 6) ? 8'h01 : 8'h03);
      name_q.push_back($sformatf("deb_latency_c%0d", j));
      tick();
    end
    rd_en = 1'b0;
    repeat (2) tick();
    do_read(8'hF1, 8'h02, "deb_sw1_rise");
    switch1 = 1'b0;
    repeat (10) tick();
    do_read(8'hF1, 8'h0A, "deb_sw1_fall");
    do_read(8'hF0, 8'h01, "deb_state_after_fall");
    do_write(8'hF1, 8'h02);
    do_read(8'hF1, 8'h08, "deb_w1c_bit1");
    do_write(8'hF1, 8'h0F);
    do_read(8'hF1, 8'h00, "deb_w1c_all");
  endtask

  // The sw0 rise flag is written on the 7th edge after the pin change;
  // a W1C of bit0 on that same edge must lose to the set
  task automatic test_collision();
    switch0 = 1'b0;
    repeat (10) tick();
    do_write(8'hF1, 8'h0F);
    do_read(8'hF1, 8'h00, "coll_pre_clear");
    switch0 = 1'b1;
    repeat (6) tick();
    do_write(8'hF1, 8'h01);
    do_read(8'hF1, 8'h01, "coll_set_wins");
    do_write(8'hF1, 8'h01);
    do_read(8'hF1, 8'h00, "coll_later_clear");
  endtask

  task automatic test_enable();
    enable = 1'b0;
    do_write(8'hF2, 8'h00);
    check_leds(1'b1, 1'b1, "en0_write_ignored");
    enable = 1'b1;
    do_write(8'hE2, 8'h00);
    check_leds(1'b1, 1'b1, "miss_write_ignored");
    enable = 1'b0;
    addr   = 8'hF0;
    rd_en  = 1'b1;
    tick();
    rd_en  = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL en0_read: rd_valid=%b expected=0", rd_valid);
    end
    enable = 1'b1;
    // Simultaneous read and write returns the pre-write value
    addr  = 8'hF2;
    wdata = 8'h00;
    wr_en = 1'b1;
    rd_en = 1'b1;
    exp_q.push_back(8'h03);
    name_q.push_back("rw_same_addr");
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_leds(1'b0, 1'b0, "rw_same_addr_leds");
    tick();
    do_read(8'hF2, 8'h00, "rw_after_write");
  endtask

  task automatic test_irq();
`ifdef IO_PORT_IRQ_EN
    do_write(8'hF1, 8'h0F);
    do_write(8'hF3, 8'h04);
    do_read(8'hF3, 8'h04, "irq_mask_read");
    switch0 = 1'b0;
    repeat (7) tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b expected=0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: irq=%b expected=1", irq);
    end
    do_write(8'hF1, 8'h04);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b expected=0", irq);
    end
`else
    do_read(8'hF3, 8'h00, "f3_reads_zero");
    do_write(8'hF3, 8'hFF);
    do_read(8'hF3, 8'h00, "f3_write_ignored");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_led();
    test_glitch();
    test_debounce();
    test_collision();
    test_enable();
    test_irq();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reads_outstanding: pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
